// File: rtl/fc_pkg.sv
// -----------------------------------------------------------------------------
// fc_pkg
//   Shared constants and state types for the fc_input_collector slice.
//   DATA_BITS / NUM_FEAT fix the frame geometry expected by fc_layer_connected.
//   Also provides the float32 exponent extraction used by the optional
//   NaN/Inf sanitizer (FC_IN_SANITIZE_EN) in the top level.
// -----------------------------------------------------------------------------
package fc_pkg;

  localparam int DATA_BITS  = 32;
  localparam int NUM_FEAT   = 128;
  localparam int IDX_BITS   = $clog2(NUM_FEAT);
  localparam int FRAME_BITS = DATA_BITS * NUM_FEAT;

  localparam logic [7:0]           FP32_EXP_ALL1 = 8'hFF;
  localparam logic [DATA_BITS-1:0] FP32_ZERO     = '0;

  typedef enum logic {
    FILL,
    RESYNC
  } wr_state_t;

  typedef enum logic [1:0] {
    IDLE,
    PRESENT,
    GAP
  } rd_state_t;

  // Biased exponent field of an IEEE-754 single-precision word.
  function automatic logic [7:0] fp32_exp(input logic [DATA_BITS-1:0] w);
    return w[30:23];
  endfunction

endpackage

// File: rtl/fc_frame_bank.sv
// -----------------------------------------------------------------------------
// fc_frame_bank
//   One NUM_FEAT x DATA_BITS frame buffer with a "full" flag.
//   Ports:
//     clk, rst_n     clock / async active-low reset (clears the full flag only)
//     we_i, idx_i,   single write port: word data_i stored at index idx_i
//     data_i
//     set_full_i     mark the bank as holding a complete frame
//     clr_full_i     release the bank after it has been presented
//     rd_bus_o       whole frame, word k at [k*DATA_BITS +: DATA_BITS]
//     full_o         bank holds a complete, not yet released frame
// -----------------------------------------------------------------------------
module fc_frame_bank
  import fc_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we_i,
  input  logic [IDX_BITS-1:0]   idx_i,
  input  logic [DATA_BITS-1:0]  data_i,
  input  logic                  set_full_i,
  input  logic                  clr_full_i,
  output logic [FRAME_BITS-1:0] rd_bus_o,
  output logic                  full_o
);

  logic [FRAME_BITS-1:0] mem_q;
  logic                  full_q;

  // Storage needs no reset: a bank is only ever read once it is full,
  // i.e. after every word of it has been rewritten.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[int'(idx_i)*DATA_BITS +: DATA_BITS] <= data_i;
    end
  end

  // Set wins over clear; the top level never asserts both for one bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
    end else if (set_full_i) begin
      full_q <= 1'b1;
    end else if (clr_full_i) begin
      full_q <= 1'b0;
    end
  end

  assign rd_bus_o = mem_q;
  assign full_o   = full_q;

endmodule

// File: rtl/fc_input_collector.sv
// -----------------------------------------------------------------------------
// fc_input_collector
//   Collects a serial stream of float32 features into NUM_FEAT-word frames
//   using two ping-pong banks, and presents each frame on a packed bus with
//   valid_out high for HOLD_CYCLES cycles followed by a one-cycle gap.
//   Ports:
//     clk, rst_n   clock / async active-low reset
//     s_data       serial feature word
//     s_valid      s_data valid
//     s_last       marks word NUM_FEAT-1 of a frame
//     s_ready      word accepted this cycle when s_valid & s_ready
//     data_out     presented frame, word k at [k*DATA_BITS +: DATA_BITS]
//     valid_out    frame valid (valid_in of fc_layer_connected)
//     frame_err    one-cycle pulse on a framing error
//     nan_cnt      count of sanitized words (saturating)
//   Build option:
//     FC_IN_SANITIZE_EN  store NaN/Inf words as +0.0 and count them in
//                        nan_cnt; otherwise words pass unchanged, nan_cnt=0.
// -----------------------------------------------------------------------------
module fc_input_collector
  import fc_pkg::*;
#(
  parameter int HOLD_CYCLES = 12
)
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_BITS-1:0]  s_data,
  input  logic                  s_valid,
  input  logic                  s_last,
  output logic                  s_ready,
  output logic [FRAME_BITS-1:0] data_out,
  output logic                  valid_out,
  output logic                  frame_err,
  output logic [15:0]           nan_cnt
);

  localparam logic [IDX_BITS-1:0] LAST_IDX  = IDX_BITS'(NUM_FEAT - 1);
  localparam logic [7:0]          HOLD_LAST = 8'(HOLD_CYCLES - 1);

  wr_state_t             wr_state_q, wr_state_d;
  logic [IDX_BITS-1:0]   wr_idx_q, wr_idx_d;
  logic                  fill_sel_q, fill_sel_d;
  logic                  frame_err_q, frame_err_d;

  rd_state_t             rd_state_q, rd_state_d;
  logic [7:0]            hold_q, hold_d;
  logic                  rd_sel_q, rd_sel_d;
  logic [FRAME_BITS-1:0] data_q, data_d;
  logic                  ready_q, ready_d;

  logic                  accept;
  logic                  bank_wr;
  logic                  frame_done;
  logic                  rd_free;
  logic [DATA_BITS-1:0]  wr_data;

  logic [1:0]            bank_we, bank_set, bank_clr, bank_full, full_next;
  logic [FRAME_BITS-1:0] bank_bus [2];

  assign accept = s_valid & ready_q;

`ifdef FC_IN_SANITIZE_EN
  logic        is_special;
  logic [15:0] nan_cnt_q, nan_cnt_d;

  assign is_special = (fp32_exp(s_data) == FP32_EXP_ALL1);
  assign wr_data    = is_special ? FP32_ZERO : s_data;

  // Only words actually written into a bank are counted; RESYNC drops
  // words without storing them.
  always_comb begin
    nan_cnt_d = nan_cnt_q;
    if (bank_wr && is_special && (nan_cnt_q != 16'hFFFF)) begin
      nan_cnt_d = nan_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nan_cnt_q <= '0;
    end else begin
      nan_cnt_q <= nan_cnt_d;
    end
  end

  assign nan_cnt = nan_cnt_q;
`else
  assign wr_data = s_data;
  assign nan_cnt = '0;
`endif

  // Write FSM: FILL stores words into the fill bank; any framing error
  // restarts the frame at index 0, and a missing s_last on the final word
  // drops into RESYNC until the stream's next s_last.
  always_comb begin
    wr_state_d  = wr_state_q;
    wr_idx_d    = wr_idx_q;
    fill_sel_d  = fill_sel_q;
    frame_err_d = 1'b0;
    bank_wr     = 1'b0;
    frame_done  = 1'b0;
    if (accept) begin
      case (wr_state_q)
        FILL: begin
          bank_wr = 1'b1;
          if (wr_idx_q == LAST_IDX) begin
            wr_idx_d = '0;
            if (s_last) begin
              frame_done = 1'b1;
              fill_sel_d = ~fill_sel_q;
            end else begin
              frame_err_d = 1'b1;
              wr_state_d  = RESYNC;
            end
          end else if (s_last) begin
            frame_err_d = 1'b1;
            wr_idx_d    = '0;
          end else begin
            wr_idx_d = wr_idx_q + 1'b1;
          end
        end
        RESYNC: begin
          if (s_last) begin
            wr_state_d = FILL;
            wr_idx_d   = '0;
          end
        end
        default: begin
          wr_state_d = FILL;
          wr_idx_d   = '0;
        end
      endcase
    end
  end

  // Read FSM: banks are consumed in the same order they are filled, so the
  // next frame to show is always in bank rd_sel. The frame is copied into
  // data_q on entry to PRESENT so it stays visible through GAP/IDLE even
  // after its bank is released and refilled.
  always_comb begin
    rd_state_d = rd_state_q;
    hold_d     = hold_q;
    rd_sel_d   = rd_sel_q;
    data_d     = data_q;
    rd_free    = 1'b0;
    case (rd_state_q)
      IDLE, GAP: begin
        if (bank_full[rd_sel_q]) begin
          rd_state_d = PRESENT;
          hold_d     = '0;
          data_d     = bank_bus[rd_sel_q];
        end else begin
          rd_state_d = IDLE;
        end
      end
      PRESENT: begin
        if (hold_q == HOLD_LAST) begin
          rd_free    = 1'b1;
          rd_sel_d   = ~rd_sel_q;
          rd_state_d = GAP;
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      default: rd_state_d = IDLE;
    endcase
  end

  // Bank control decode and back-pressure. s_ready is registered from the
  // next-cycle full flags, so it falls on the same edge the second bank
  // fills and rises on the edge a bank is freed.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      bank_we[b]   = bank_wr    & (fill_sel_q == 1'(b));
      bank_set[b]  = frame_done & (fill_sel_q == 1'(b));
      bank_clr[b]  = rd_free    & (rd_sel_q   == 1'(b));
      full_next[b] = bank_set[b] | (bank_full[b] & ~bank_clr[b]);
    end
    ready_d = ~(&full_next);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state_q  <= FILL;
      wr_idx_q    <= '0;
      fill_sel_q  <= 1'b0;
      frame_err_q <= 1'b0;
      rd_state_q  <= IDLE;
      hold_q      <= '0;
      rd_sel_q    <= 1'b0;
      data_q      <= '0;
      ready_q     <= 1'b0;
    end else begin
      wr_state_q  <= wr_state_d;
      wr_idx_q    <= wr_idx_d;
      fill_sel_q  <= fill_sel_d;
      frame_err_q <= frame_err_d;
      rd_state_q  <= rd_state_d;
      hold_q      <= hold_d;
      rd_sel_q    <= rd_sel_d;
      data_q      <= data_d;
      ready_q     <= ready_d;
    end
  end

  for (genvar g = 0; g < 2; g++) begin : gen_bank
    fc_frame_bank u_bank (
      .clk        (clk),
      .rst_n      (rst_n),
      .we_i       (bank_we[g]),
      .idx_i      (wr_idx_q),
      .data_i     (wr_data),
      .set_full_i (bank_set[g]),
      .clr_full_i (bank_clr[g]),
      .rd_bus_o   (bank_bus[g]),
      .full_o     (bank_full[g])
    );
  end

  assign s_ready   = ready_q;
  assign data_out  = data_q;
  assign valid_out = (rd_state_q == PRESENT);
  assign frame_err = frame_err_q;

endmodule
